stop_watch_lap: RTL

// - Parametrised successor stopwatch: HH:MM:SS BCD timer with start/stop toggle, clear, lap-hold display.
// - Single clock domain: internal prescaler drives a tick enable; no derived clock.
// - Buttons are asynchronous to Clk and are synchronised internally.
// - Drives a 6-digit BCD display path; the counting core stays live while the display is held.

---
 rtl/stop_watch_lap.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/stop_watch_lap.sv
// Purpose: HH:MM:SS BCD stopwatch with run/pause toggle, clear and lap-hold display; buttons synchronised internally.
// Latency: button effect lands on the 3rd Clk edge after first sample (SYNC_STAGES=2); time update visible 1 cycle after tick.
// Backpressure: none; events are single-cycle pulses. Optional STOPWATCH_OVF_STOP_EN: stop at max with sticky ovf instead of wrapping.
module stop_watch_lap #(
    parameter int CLK_FREQ    = 10_000_000,
    parameter int TICK_FREQ   = 1,
    parameter int HR_WRAP     = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic       Clk,
    input  logic       rst,
    input  logic       start_stop,
    input  logic       Clear,
    input  logic       lap,
    output logic [3:0] hr_h,
    output logic [3:0] hr_l,
    output logic [3:0] min_h,
    output logic [3:0] min_l,
    output logic [3:0] sec_h,
    output logic [3:0] sec_l,
    output logic       running,
    output logic       lap_hold,
    output logic       wrap,
    output logic       ovf
);

    localparam int DIV = CLK_FREQ / TICK_FREQ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
    localparam logic [3:0] HR_MAX_H = 4'((HR_WRAP - 1) / 10);
    localparam logic [3:0] HR_MAX_L = 4'((HR_WRAP - 1) % 10);

    typedef struct packed {
        logic [3:0] hr_h;
        logic [3:0] hr_l;
        logic [3:0] min_h;
        logic [3:0] min_l;
        logic [3:0] sec_h;
        logic [3:0] sec_l;
    } bcd_time_t;

    localparam bcd_time_t TIME_MAX = '{HR_MAX_H, HR_MAX_L, 4'd5, 4'd9, 4'd5, 4'd9};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // Button index: 0 = start_stop, 1 = Clear, 2 = lap
    logic [2:0]                  btn_in;
    logic [2:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [2:0]                  prev_q, prev_d;
    logic [2:0]                  btn_ev;

    state_t    state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    bcd_time_t core_q, core_d, core_inc;
    bcd_time_t lap_q, lap_d;
    logic      lap_hold_q, lap_hold_d;
    logic      wrap_q, wrap_d;
    logic      ovf_q, ovf_d;

    logic clr_ev, ss_ev, lap_ev, tick, at_max;
    bcd_time_t disp;

    assign btn_in = {lap, Clear, start_stop};

    // Synchroniser shift and rising-edge detect on the last stage
    always_comb begin
        sync_d = sync_q;
        prev_d = prev_q;
        btn_ev = '0;
        for (int i = 0; i < 3; i++) begin
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], btn_in[i]};
            prev_d[i] = sync_q[i][SYNC_STAGES-1];
            btn_ev[i] = sync_q[i][SYNC_STAGES-1] & ~prev_q[i];
        end
    end

    // Priority Clear > start_stop > lap; a lower event in the same cycle is dropped.
    // After an overflow stop, start_stop is swallowed until Clear.
    assign clr_ev = btn_ev[1];
    assign ss_ev  = btn_ev[0] & ~btn_ev[1] & ~ovf_q;
    assign lap_ev = btn_ev[2] & ~btn_ev[1] & ~btn_ev[0];
    assign tick   = (state_q == ST_RUN) && (presc_q == PRESC_MAX);
    assign at_max = (core_q == TIME_MAX);

    // BCD increment with full carry ripple in one cycle
    always_comb begin
        core_inc = core_q;
        if (core_q.sec_l != 4'd9) begin
            core_inc.sec_l = core_q.sec_l + 4'd1;
        end else begin
            core_inc.sec_l = 4'd0;
            if (core_q.sec_h != 4'd5) begin
                core_inc.sec_h = core_q.sec_h + 4'd1;
            end else begin
                core_inc.sec_h = 4'd0;
                if (core_q.min_l != 4'd9) begin
                    core_inc.min_l = core_q.min_l + 4'd1;
                end else begin
                    core_inc.min_l = 4'd0;
                    if (core_q.min_h != 4'd5) begin
                        core_inc.min_h = core_q.min_h + 4'd1;
                    end else begin
                        core_inc.min_h = 4'd0;
                        if (core_q.hr_h == HR_MAX_H && core_q.hr_l == HR_MAX_L) begin
                            core_inc.hr_h = 4'd0;
                            core_inc.hr_l = 4'd0;
                        end else if (core_q.hr_l != 4'd9) begin
                            core_inc.hr_l = core_q.hr_l + 4'd1;
                        end else begin
                            core_inc.hr_l = 4'd0;
                            core_inc.hr_h = core_q.hr_h + 4'd1;
                        end
                    end
                end
            end
        end
    end

    // FSM next state, prescaler, time core and lap register
    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        core_d     = core_q;
        lap_d      = lap_q;
        lap_hold_d = lap_hold_q;
        wrap_d     = 1'b0;
        ovf_d      = ovf_q;

        // Prescaler keeps its partial count across PAUSE
        case (state_q)
            ST_RUN:   presc_d = tick ? '0 : presc_q + PW'(1);
            ST_PAUSE: presc_d = presc_q;
            default:  presc_d = '0;
        endcase

        if (tick) begin
`ifdef STOPWATCH_OVF_STOP_EN
            if (at_max) begin
                ovf_d   = 1'b1;
                state_d = ST_PAUSE;
            end else begin
                core_d = core_inc;
            end
`else
            core_d = core_inc;
            wrap_d = at_max;
`endif
        end

`ifndef STOPWATCH_OVF_STOP_EN
        ovf_d = 1'b0;
`endif

        if (clr_ev) begin
            state_d    = ST_IDLE;
            presc_d    = '0;
            core_d     = '0;
            lap_d      = '0;
            lap_hold_d = 1'b0;
            wrap_d     = 1'b0;
            ovf_d      = 1'b0;
        end else if (ss_ev) begin
            case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end else if (lap_ev) begin
            if (state_q == ST_RUN) begin
                lap_d      = core_d;
                lap_hold_d = 1'b1;
            end else if (state_q == ST_PAUSE) begin
                lap_hold_d = 1'b0;
            end
        end
    end

    // State registers, all cleared asynchronously
    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            sync_q     <= '0;
            prev_q     <= '0;
            state_q    <= ST_IDLE;
            presc_q    <= '0;
            core_q     <= '0;
            lap_q      <= '0;
            lap_hold_q <= 1'b0;
            wrap_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            state_q    <= state_d;
            presc_q    <= presc_d;
            core_q     <= core_d;
            lap_q      <= lap_d;
            lap_hold_q <= lap_hold_d;
            wrap_q     <= wrap_d;
            ovf_q      <= ovf_d;
        end
    end

    assign disp     = lap_hold_q ? lap_q : core_q;
    assign hr_h     = disp.hr_h;
    assign hr_l     = disp.hr_l;
    assign min_h    = disp.min_h;
    assign min_l    = disp.min_l;
    assign sec_h    = disp.sec_h;
    assign sec_l    = disp.sec_l;
    assign running  = (state_q == ST_RUN);
    assign lap_hold = lap_hold_q;
    assign wrap     = wrap_q;
    assign ovf      = ovf_q;

endmodule
